// File: rtl/delayed_toggle_bank.sv
// delayed_toggle_bank: WIDTH independent channels. Each channel inverts its q
// output LATENCY rising edges after a toggle request is captured. A pending
// toggle can be cancelled, a request that arrives while one is in flight is
// dropped and flagged as overrun, and a synchronous clear wipes every channel.
module delayed_toggle_bank #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] toggle,
    input  logic [WIDTH-1:0] cancel,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] done,
    output logic [WIDTH-1:0] overrun,
    output logic             busy
);

    localparam int unsigned CW = $clog2(LATENCY + 1);

    localparam logic [CW-1:0] C_LOAD = CW'(LATENCY);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_done;
    logic [WIDTH-1:0] r_overrun;

    // Per-channel capture / countdown / apply / cancel with clear taking
    // priority over everything; cancel wins over a same-edge apply.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_q       <= '0;
            r_done    <= '0;
            r_overrun <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (clear) begin
            r_pending <= '0;
            r_q       <= '0;
            r_done    <= '0;
            r_overrun <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (r_pending[i]) begin
                    if (cancel[i]) begin
                        r_pending[i] <= 1'b0;
                        r_cnt[i]     <= '0;
                        r_done[i]    <= 1'b0;
                    end else begin
                        if (toggle[i]) begin
                            r_overrun[i] <= 1'b1;
                        end
                        if (r_cnt[i] == C_ONE) begin
                            r_q[i]       <= ~r_q[i];
                            r_pending[i] <= 1'b0;
                            r_cnt[i]     <= '0;
                            r_done[i]    <= 1'b1;
                        end else begin
                            r_cnt[i]  <= r_cnt[i] - C_ONE;
                            r_done[i] <= 1'b0;
                        end
                    end
                end else begin
                    r_done[i] <= 1'b0;
                    if (toggle[i] && !cancel[i]) begin
                        r_pending[i] <= 1'b1;
                        r_cnt[i]     <= C_LOAD;
                    end
                end
            end
        end
    end

    assign q       = r_q;
    assign pending = r_pending;
    assign done    = r_done;
    assign overrun = r_overrun;
    assign busy    = |r_pending;

endmodule

// File: tb/tb_delayed_toggle_bank.sv
// Bench for delayed_toggle_bank: two instances (LATENCY=2 and LATENCY=1) share
// stimulus and are checked every cycle against an edge-numbered reference model.
module tb_delayed_toggle_bank;

    localparam int W    = 4;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         clear;
    logic [W-1:0] toggle;
    logic [W-1:0] cancel;
    logic [W-1:0] q0, p0, d0, o0;
    logic [W-1:0] q1, p1, d1, o1;
    logic         b0, b1;

    always #5 clock = ~clock;

    delayed_toggle_bank #(.WIDTH(W), .LATENCY(LAT0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .toggle(toggle), .cancel(cancel),
        .q(q0), .pending(p0), .done(d0), .overrun(o0), .busy(b0)
    );

    delayed_toggle_bank #(.WIDTH(W), .LATENCY(LAT1)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .toggle(toggle), .cancel(cancel),
        .q(q1), .pending(p1), .done(d1), .overrun(o1), .busy(b1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a toggle is due at an absolute edge number.
    int n_edge;
    bit m_pend [2][W];
    int m_due  [2][W];
    bit m_q    [2][W];
    bit m_done [2][W];
    bit m_ovr  [2][W];
    int lat    [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < W; i++) begin
                m_pend[d][i] = 0; m_due[d][i] = 0; m_q[d][i] = 0;
                m_done[d][i] = 0; m_ovr[d][i] = 0;
            end
        end
    endtask

    task automatic model_edge(input logic [W-1:0] tg, input logic [W-1:0] cn, input bit cl);
        n_edge++;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < W; i++) begin
                if (cl) begin
                    m_pend[d][i] = 0; m_q[d][i] = 0; m_done[d][i] = 0; m_ovr[d][i] = 0;
                end else if (m_pend[d][i]) begin
                    if (cn[i]) begin
                        m_pend[d][i] = 0;
                        m_done[d][i] = 0;
                    end else begin
                        if (tg[i]) m_ovr[d][i] = 1;
                        if (n_edge == m_due[d][i]) begin
                            m_q[d][i]    = !m_q[d][i];
                            m_pend[d][i] = 0;
                            m_done[d][i] = 1;
                        end else begin
                            m_done[d][i] = 0;
                        end
                    end
                end else begin
                    m_done[d][i] = 0;
                    if (tg[i] && !cn[i]) begin
                        m_pend[d][i] = 1;
                        m_due[d][i]  = n_edge + lat[d];
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] eq, ep, ed, eo;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < W; i++) begin
                eq[i] = m_q[d][i]; ep[i] = m_pend[d][i];
                ed[i] = m_done[d][i]; eo[i] = m_ovr[d][i];
            end
            if (d == 0) begin
                check_eq({tag, "_q0"}, 32'(q0), 32'(eq));
                check_eq({tag, "_pend0"}, 32'(p0), 32'(ep));
                check_eq({tag, "_done0"}, 32'(d0), 32'(ed));
                check_eq({tag, "_ovr0"}, 32'(o0), 32'(eo));
                check_eq({tag, "_busy0"}, 32'(b0), 32'(|ep));
            end else begin
                check_eq({tag, "_q1"}, 32'(q1), 32'(eq));
                check_eq({tag, "_pend1"}, 32'(p1), 32'(ep));
                check_eq({tag, "_done1"}, 32'(d1), 32'(ed));
                check_eq({tag, "_ovr1"}, 32'(o1), 32'(eo));
                check_eq({tag, "_busy1"}, 32'(b1), 32'(|ep));
            end
        end
    endtask

    // Drive inputs, take one rising edge, then check 1 time unit later.
    task automatic step(input string tag, input logic [W-1:0] tg, input logic [W-1:0] cn, input bit cl);
        toggle = tg;
        cancel = cn;
        clear  = cl;
        @(posedge clock);
        if (reset_n) model_edge(tg, cn, cl);
        #1;
        check_all(tag);
    endtask

    // Assert reset mid-cycle and verify outputs clear without a clock edge.
    task automatic async_reset_assert();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check_eq("async_rst_q0", 32'(q0), 32'(0));
    endtask

    task automatic async_reset_release();
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        lat[0] = LAT0;
        lat[1] = LAT1;
        n_edge = 0;
        model_reset();
        reset_n = 1'b0;
        clear   = 1'b0;
        toggle  = '0;
        cancel  = '0;
        #2;
        check_all("reset");
        reset_n = 1'b1;

        // Basic toggle, captured on the first edge after reset release
        step("basic_e0", 4'b0001, 4'b0000, 0);
        check_eq("basic_e0_pend", 32'(p0), 32'(4'b0001));
        step("basic_e1", 4'b0000, 4'b0000, 0);
        check_eq("basic_e1_pend", 32'(p0), 32'(4'b0001));
        check_eq("basic_lat1_q", 32'(q1), 32'(4'b0001));
        step("basic_e2", 4'b0000, 4'b0000, 0);
        check_eq("basic_e2_q", 32'(q0), 32'(4'b0001));
        check_eq("basic_e2_done", 32'(d0), 32'(4'b0001));
        check_eq("basic_e2_busy", 32'(b0), 32'(0));
        step("basic_e3", 4'b0000, 4'b0000, 0);
        check_eq("basic_e3_done", 32'(d0), 32'(0));
        step("clr0", 4'b0000, 4'b0000, 1);

        // Late cancel on the apply edge
        step("lc_e0", 4'b0010, 4'b0000, 0);
        step("lc_e1", 4'b0000, 4'b0000, 0);
        step("lc_e2", 4'b0000, 4'b0010, 0);
        check_eq("lc_q", 32'(q0), 32'(0));
        check_eq("lc_done", 32'(d0), 32'(0));
        check_eq("lc_pend", 32'(p0), 32'(0));

        // Overrun, sticky until clear
        step("ov_e0", 4'b0100, 4'b0000, 0);
        step("ov_e1", 4'b0100, 4'b0000, 0);
        step("ov_e2", 4'b0000, 4'b0000, 0);
        check_eq("ov_q", 32'(q0), 32'(4'b0100));
        check_eq("ov_flag", 32'(o0), 32'(4'b0100));
        step("ov_e3", 4'b0000, 4'b0000, 0);
        check_eq("ov_sticky", 32'(o0), 32'(4'b0100));
        step("ov_clr", 4'b1111, 4'b0000, 1);
        check_eq("ov_clr_q", 32'(q0), 32'(0));
        check_eq("ov_clr_ovr", 32'(o0), 32'(0));
        check_eq("ov_clr_pend", 32'(p0), 32'(0));

        // Independent channels
        step("ind_e0", 4'b1111, 4'b0000, 0);
        step("ind_e1", 4'b0000, 4'b0101, 0);
        step("ind_e2", 4'b0000, 4'b0000, 0);
        check_eq("ind_q", 32'(q0), 32'(4'b1010));
        check_eq("ind_done", 32'(d0), 32'(4'b1010));
        step("clr1", 4'b0000, 4'b0000, 1);

        // Reset mid-flight; toggle applied while in reset is ignored
        step("rm_e0", 4'b1000, 4'b0000, 0);
        step("rm_e1", 4'b0000, 4'b0000, 0);
        async_reset_assert();
        step("rm_e2", 4'b1111, 4'b0000, 1);
        check_eq("rm_e2_pend", 32'(p0), 32'(0));
        async_reset_release();
        step("rm_e3", 4'b1000, 4'b0000, 0);
        check_eq("rm_e3_done", 32'(d0), 32'(0));
        step("rm_e4", 4'b0000, 4'b0000, 0);
        check_eq("rm_e4_q", 32'(q0), 32'(0));
        step("rm_e5", 4'b0000, 4'b0000, 0);
        check_eq("rm_e5_q", 32'(q0), 32'(4'b1000));

        // Randomized traffic with occasional clear and asynchronous reset
        for (int n = 0; n < 600; n++) begin
            logic [W-1:0] tg, cn;
            bit cl;
            tg = W'($urandom);
            cn = W'($urandom) & W'($urandom);
            cl = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 149) == 0) begin
                async_reset_assert();
                step("rnd_inrst", tg, cn, cl);
                async_reset_release();
            end else begin
                step("rnd", tg, cn, cl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard so the run always ends
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout got=running exp=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delayed_toggle_bank.md
DELAYED_TOGGLE_BANK -- requirements
Module: delayed_toggle_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, number of independent toggle channels (1..32).
REQ-002 The block SHALL have parameter LATENCY, default 2, rising edges from request capture to output toggle (1..15).
REQ-003 The block SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port clear  input  1  synchronous clear of all channels.
REQ-006 The block SHALL have port toggle  input  WIDTH  per-channel toggle request, sampled each rising edge.
REQ-007 The block SHALL have port cancel  input  WIDTH  per-channel abort of a pending toggle.
REQ-008 The block SHALL have port q  output  WIDTH  per-channel toggle state.
REQ-009 The block SHALL have port pending  output  WIDTH  per-channel flag, high while a toggle is in flight.
REQ-010 The block SHALL have port done  output  WIDTH  per-channel one-cycle pulse after a toggle is applied.
REQ-011 The block SHALL have port overrun  output  WIDTH  per-channel sticky flag for a dropped request.
REQ-012 The block SHALL have port busy  output  1  OR of all pending bits, combinational.

Function
REQ-013 Each channel SHALL hold a down-counter of ceil(log2(LATENCY+1)) bits, a pending bit, q, done and overrun, and SHALL be independent of all other channels.
REQ-014 Capture: on edge E0 with toggle[i]=1, pending[i]=0, cancel[i]=0 and clear=0, the block SHALL set pending[i]=1 and load counter[i]=LATENCY.
REQ-015 Countdown: on each edge with pending[i]=1 and no cancel, the block SHALL decrement counter[i].
REQ-016 Apply: on the edge where counter[i] goes 1->0 (edge E0+LATENCY), the block SHALL invert q[i], clear pending[i] and set done[i]=1 for exactly one cycle.
REQ-017 Cancel: on any edge with pending[i]=1 and cancel[i]=1, including the apply edge, the block SHALL clear pending[i] and leave q[i] unchanged; cancel SHALL win over apply, and done[i] SHALL stay 0.
REQ-018 A cancel[i] sampled with pending[i]=0 SHALL have no effect other than to block a simultaneous toggle[i] capture.
REQ-019 A toggle[i] sampled with pending[i]=1 (including the apply edge) and cancel[i]=0 SHALL be dropped and SHALL set overrun[i]=1.
REQ-020 overrun[i] SHALL remain 1 until clear or reset.
REQ-021 clear=1 on an edge SHALL force q=0, pending=0, done=0, overrun=0 and counters=0 for all channels; it SHALL take priority over toggle, cancel and apply.
REQ-022 done[i] SHALL be 0 on every edge other than an apply edge for channel i.
REQ-023 With LATENCY=1, q[i] SHALL invert on the edge immediately after the capture edge.
REQ-024 busy SHALL equal the reduction OR of pending with no register delay.

Reset
REQ-025 reset_n=0 SHALL immediately, without a clock edge, force q=0, pending=0, done=0, overrun=0 and counters=0.
REQ-026 While reset_n=0, all inputs SHALL be ignored.
REQ-027 The first edge after reset_n rises SHALL be able to capture a toggle.
REQ-028 Reset asserted mid-countdown SHALL discard the in-flight toggle, with no done pulse and no q change after release.

Verification (WIDTH=4, LATENCY=2)
REQ-029 Basic toggle: toggle=0001 for one edge E0 -> pending=0001 after E0 and E1; after E2, q=0001, pending=0000, done=0001 for one cycle, busy falls.
REQ-030 Late cancel: toggle=0010 at E0, cancel=0010 at E2 -> q stays 0000, done stays 0000, pending=0000 after E2.
REQ-031 Overrun: toggle=0100 at E0 and again at E1 -> q=0100 after E2, overrun=0100 sticky; a clear pulse -> q=0000, overrun=0000.
REQ-032 Independent channels: toggle=1111 at E0, cancel=0101 at E1 -> after E2, q=1010 and done=1010.
REQ-033 Reset mid-flight: toggle=1000 at E0, reset_n low between E1 and E2, released before E3 -> q=0000, pending=0000, done never 1; toggle=1000 at E3 -> q=1000 after E5.
